bot_batch_feeder: RTL and testbench

- Transmit side of the bot-stream interface consumed by the aggregating pipeline.
- Accepts batch descriptors (top, bot count) and a raw bot stream, then drives `top`, `isBotValid`, `bot` and `lastBotOfBatch` into the pipeline, honouring `slowDownInput`.
- Tracks how many batches are in flight so `top` never changes while results for the old top are outstanding.

---
 rtl/bot_batch_feeder.sv | 188 ++++++++++++++++++
 tb/tb_bot_batch_feeder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_batch_feeder.sv
// bot_batch_feeder: transmit side of the bot-stream interface.
// Takes batch descriptors (top, bot count) plus a raw bot stream and feeds
// top/isBotValid/bot/lastBotOfBatch to the aggregating pipeline. A new top
// is only applied once every batch issued under the old top has resolved.
// Optional build macro: BOT_BATCH_FEEDER_COUNT_CHECK_EN adds a FIFO of issued
// batch counts that is checked against the pipeline's pcoeffCount.
`default_nettype none

module bot_batch_feeder #(
    parameter int PCOEFF_COUNT_BITWIDTH = 10,
    parameter int MAX_IN_FLIGHT         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 descValid,
    input  logic [127:0]                         descTop,
    input  logic [PCOEFF_COUNT_BITWIDTH-1:0]     descBotCount,
    output logic                                 descReady,
    input  logic                                 botInValid,
    input  logic [127:0]                         botIn,
    output logic                                 botInReady,
    output logic [127:0]                         top,
    output logic                                 isBotValid,
    output logic [127:0]                         bot,
    output logic                                 lastBotOfBatch,
    input  logic                                 slowDownInput,
    input  logic                                 resultsValid,
    input  logic [PCOEFF_COUNT_BITWIDTH-1:0]     pcoeffCount,
    output logic [$clog2(MAX_IN_FLIGHT):0]       batchesInFlight,
    output logic                                 idle,
    output logic                                 countMismatch
);

    localparam int CNT_W = $clog2(MAX_IN_FLIGHT) + 1;
    localparam logic [PCOEFF_COUNT_BITWIDTH-1:0] ONE_BOT = PCOEFF_COUNT_BITWIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        STREAM
    } state_t;

    state_t                             state;
    logic [PCOEFF_COUNT_BITWIDTH-1:0]   remaining;
    logic [PCOEFF_COUNT_BITWIDTH-1:0]   pendCount;
    logic [127:0]                       pendTop;

    logic descAccept;
    logic botAccept;
    logic lastIssue;
    logic resultPop;

    // Handshakes: descriptors only in IDLE with room, bots only while streaming.
    assign descReady  = (state == IDLE) && (batchesInFlight < CNT_W'(MAX_IN_FLIGHT));
    assign botInReady = (state == STREAM) && !slowDownInput;
    assign descAccept = descValid && descReady;
    assign botAccept  = botInValid && botInReady;
    assign lastIssue  = botAccept && (remaining == ONE_BOT);
    // A result with nothing in flight is unexpected and must not underflow.
    assign resultPop  = resultsValid && (batchesInFlight != '0);
    assign idle       = (state == IDLE) && (batchesInFlight == '0);

    // Batch sequencing FSM with registered pipeline-facing outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            top            <= '0;
            bot            <= '0;
            isBotValid     <= 1'b0;
            lastBotOfBatch <= 1'b0;
            remaining      <= '0;
            pendTop        <= '0;
            pendCount      <= '0;
        end else begin
            isBotValid     <= botAccept;
            lastBotOfBatch <= lastIssue;
            if (botAccept) begin
                bot <= botIn;
            end
            case (state)
                IDLE: begin
                    // Zero-bot descriptors are consumed and dropped.
                    if (descAccept && (descBotCount != '0)) begin
                        if ((descTop == top) || (batchesInFlight == '0)) begin
                            top       <= descTop;
                            remaining <= descBotCount;
                            state     <= STREAM;
                        end else begin
                            pendTop   <= descTop;
                            pendCount <= descBotCount;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Old-top results all resolved: safe to switch top.
                    if (batchesInFlight == '0) begin
                        top       <= pendTop;
                        remaining <= pendCount;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (botAccept) begin
                        remaining <= remaining - ONE_BOT;
                        if (lastIssue) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-flight counter: +1 per issued last bot, -1 per resolved result.
    always_ff @(posedge clk) begin
        if (rst) begin
            batchesInFlight <= '0;
        end else if (lastIssue && !resultPop) begin
            batchesInFlight <= batchesInFlight + CNT_W'(1);
        end else if (!lastIssue && resultPop) begin
            batchesInFlight <= batchesInFlight - CNT_W'(1);
        end
    end

`ifdef BOT_BATCH_FEEDER_COUNT_CHECK_EN
    localparam int PTR_W = $clog2(MAX_IN_FLIGHT);

    logic [PCOEFF_COUNT_BITWIDTH-1:0] countFifo [MAX_IN_FLIGHT];
    logic [PTR_W-1:0]                 wrPtr;
    logic [PTR_W-1:0]                 rdPtr;
    logic [PCOEFF_COUNT_BITWIDTH-1:0] batchCount;

    // Count of the batch that will stream next; at most one is outstanding
    // in IDLE/DRAIN, so the accepted non-zero descriptor always owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            batchCount <= '0;
        end else if (descAccept && (descBotCount != '0)) begin
            batchCount <= descBotCount;
        end
    end

    // FIFO storage of issued batch counts.
    // NOTE: the storage array has no reset; the pointers define which entries
    // are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (lastIssue) begin
            countFifo[wrPtr] <= batchCount;
        end
    end

    // FIFO pointers; depth is a power of two so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (lastIssue) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (resultPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    // Sticky mismatch: wrong count, or a result nobody was waiting for.
    always_ff @(posedge clk) begin
        if (rst) begin
            countMismatch <= 1'b0;
        end else if (resultsValid &&
                     ((batchesInFlight == '0) || (countFifo[rdPtr] != pcoeffCount))) begin
            countMismatch <= 1'b1;
        end
    end
`else
    logic unusedPcoeff;
    assign unusedPcoeff  = ^pcoeffCount;
    assign countMismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bot_batch_feeder.sv
// Self-checking bench for bot_batch_feeder. A transaction-level model (queue
// of in-flight batch counts, current top, bots left in the current batch,
// pending descriptor) predicts every output once per cycle.
`timescale 1ns/1ps

module tb_bot_batch_feeder;

    localparam int W    = 10;
    localparam int MAXF = 8;
    localparam int CW   = $clog2(MAXF) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           descValid = 1'b0;
    logic [127:0]   descTop = '0;
    logic [W-1:0]   descBotCount = '0;
    logic           descReady;
    logic           botInValid = 1'b0;
    logic [127:0]   botIn = '0;
    logic           botInReady;
    logic [127:0]   top;
    logic           isBotValid;
    logic [127:0]   bot;
    logic           lastBotOfBatch;
    logic           slowDownInput = 1'b0;
    logic           resultsValid = 1'b0;
    logic [W-1:0]   pcoeffCount = '0;
    logic [CW-1:0]  batchesInFlight;
    logic           idle;
    logic           countMismatch;

    bot_batch_feeder #(
        .PCOEFF_COUNT_BITWIDTH(W),
        .MAX_IN_FLIGHT(MAXF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .descValid(descValid),
        .descTop(descTop),
        .descBotCount(descBotCount),
        .descReady(descReady),
        .botInValid(botInValid),
        .botIn(botIn),
        .botInReady(botInReady),
        .top(top),
        .isBotValid(isBotValid),
        .bot(bot),
        .lastBotOfBatch(lastBotOfBatch),
        .slowDownInput(slowDownInput),
        .resultsValid(resultsValid),
        .pcoeffCount(pcoeffCount),
        .batchesInFlight(batchesInFlight),
        .idle(idle),
        .countMismatch(countMismatch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [127:0] mTop, mBot, pTop;
    logic         mValid, mLast, mMism, pendValid;
    int           mRemain;
    logic [W-1:0] pCount, curCount;
    logic [W-1:0] flightQ[$];
    bit           descTaken, botTaken;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic modelReset();
        mTop = '0; mBot = '0; pTop = '0;
        mValid = 1'b0; mLast = 1'b0; mMism = 1'b0; pendValid = 1'b0;
        mRemain = 0; pCount = '0; curCount = '0;
        flightQ.delete();
    endtask

    // Check all outputs against the model, then advance model and DUT one cycle.
    task automatic tick();
        bit streaming, draining, expDescReady, expBotReady;
        bit accDesc, accBot, issue, resolved;
        #1;
        streaming    = (mRemain != 0);
        draining     = pendValid;
        expDescReady = !streaming && !draining && (flightQ.size() < MAXF);
        expBotReady  = streaming && !slowDownInput;
        check("descReady", descReady, expDescReady);
        check("botInReady", botInReady, expBotReady);
        check("idle", idle, !streaming && !draining && (flightQ.size() == 0));
        check("top", top, mTop);
        check("isBotValid", isBotValid, mValid);
        check("lastBotOfBatch", lastBotOfBatch, mLast);
        if (mValid) check("bot", bot, mBot);
        check("batchesInFlight", batchesInFlight, flightQ.size());
        check("countMismatch", countMismatch, mMism);

        descTaken = 1'b0;
        botTaken  = 1'b0;
        if (rst) begin
            modelReset();
        end else begin
            accDesc  = descValid && expDescReady;
            accBot   = botInValid && expBotReady;
            issue    = accBot && (mRemain == 1);
            resolved = resultsValid && (flightQ.size() != 0);
            mValid   = accBot;
            mLast    = issue;
            if (accBot) begin
                mBot = botIn;
                mRemain--;
            end
            if (accDesc && (descBotCount != '0)) begin
                curCount = descBotCount;
                if ((descTop == mTop) || (flightQ.size() == 0)) begin
                    mTop    = descTop;
                    mRemain = descBotCount;
                end else begin
                    pendValid = 1'b1;
                    pTop      = descTop;
                    pCount    = descBotCount;
                end
            end
            if (draining && (flightQ.size() == 0)) begin
                mTop      = pTop;
                mRemain   = pCount;
                pendValid = 1'b0;
            end
`ifdef BOT_BATCH_FEEDER_COUNT_CHECK_EN
            if (resultsValid && (!resolved || (flightQ[0] != pcoeffCount))) mMism = 1'b1;
`endif
            if (resolved) void'(flightQ.pop_front());
            if (issue) flightQ.push_back(curCount);
            descTaken = accDesc;
            botTaken  = accBot;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic sendDesc(input logic [127:0] t, input int cnt);
        descValid    = 1'b1;
        descTop      = t;
        descBotCount = cnt[W-1:0];
        for (int i = 0; i < 50; i++) begin
            tick();
            if (descTaken) break;
        end
        check("descAccepted", descTaken, 1'b1);
        descValid = 1'b0;
    endtask

    task automatic sendBots(input int n);
        int got = 0;
        botInValid = 1'b1;
        botIn      = rand128();
        for (int i = 0; i < 200 && got < n; i++) begin
            tick();
            if (botTaken) begin
                got++;
                botIn = rand128();
            end
        end
        check("botsAccepted", got, n);
        botInValid = 1'b0;
    endtask

    task automatic result(input int cnt);
        resultsValid = 1'b1;
        pcoeffCount  = cnt[W-1:0];
        tick();
        resultsValid = 1'b0;
    endtask

    task automatic idleTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [127:0] t1, t2, tA, tB;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        rst = 1'b0;

        // Reset state, then one batch of 3 back-to-back and its result.
        idleTicks(1);
        t1 = rand128();
        t2 = t1 ^ 128'h1;
        sendDesc(t1, 3);
        sendBots(3);
        idleTicks(1);
        result(3);
        idleTicks(1);

        // Same-top batches stream without draining; a new top waits in DRAIN.
        sendDesc(t1, 2);
        sendBots(2);
        sendDesc(t1, 2);
        sendBots(2);
        sendDesc(t2, 1);
        botInValid = 1'b1;
        botIn      = rand128();
        idleTicks(3);
        result(2);
        result(2);
        sendBots(1);
        result(1);

        // Backpressure mid-batch of 4.
        sendDesc(t2, 4);
        sendBots(1);
        botInValid    = 1'b1;
        slowDownInput = 1'b1;
        idleTicks(5);
        slowDownInput = 1'b0;
        sendBots(3);
        result(4);

        // Fill to MAX_IN_FLIGHT, then issue a 9th last-bot alongside a result.
        for (int i = 0; i < MAXF; i++) begin
            sendDesc(t2, 1);
            sendBots(1);
        end
        descValid    = 1'b1;
        descTop      = t2;
        descBotCount = W'(1);
        idleTicks(2);
        result(1);
        sendDesc(t2, 1);
        botInValid   = 1'b1;
        botIn        = rand128();
        resultsValid = 1'b1;
        pcoeffCount  = W'(1);
        tick();
        resultsValid = 1'b0;
        botInValid   = 1'b0;
        for (int i = 0; i < MAXF - 1; i++) result(1);
        idleTicks(1);

        // Zero-count descriptor issues nothing.
        sendDesc(t1, 0);
        botInValid = 1'b1;
        idleTicks(3);
        botInValid = 1'b0;

        // Wrong result count, sticky until reset; then an unexpected result.
        sendDesc(t1, 3);
        sendBots(3);
        result(2);
        idleTicks(3);
        doReset();
        idleTicks(1);
        result(5);
        idleTicks(2);
        doReset();

        // Reset in the middle of a 5-bot batch.
        sendDesc(t1, 5);
        sendBots(2);
        botInValid = 1'b1;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        botInValid = 1'b0;
        idleTicks(2);

        // Randomized traffic with well-formed results.
        tA = rand128();
        tB = rand128();
        for (int i = 0; i < 600; i++) begin
            descValid     = ($urandom % 3) == 0;
            descTop       = ($urandom % 2) ? tA : tB;
            descBotCount  = W'($urandom_range(0, 4));
            botInValid    = ($urandom % 4) != 0;
            botIn         = rand128();
            slowDownInput = ($urandom % 4) == 0;
            resultsValid  = (flightQ.size() != 0) && (($urandom % 4) == 0);
            pcoeffCount   = resultsValid ? flightQ[0] : W'($urandom % 8);
            tick();
        end
        descValid     = 1'b0;
        botInValid    = 1'b0;
        slowDownInput = 1'b0;
        resultsValid  = 1'b0;
        idleTicks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
